score_counter: RTL

- Producer side of the score path: owns the 8-bit game score that the score renderer consumes, and supplies the hundreds/tens/ones digits.
- Score increments on a press of the move button and keeps incrementing at a fixed frame rate while the button is held.
- Score freezes on collision and clears on restart.
- A sequential double-dabble converter turns the binary score into BCD, so the renderer needs no divide/modulo logic.

---
 rtl/score_counter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/score_counter.sv
// score_counter: owns the 8-bit game score (tap / hold-to-repeat increments,
// freeze on collision, clear on restart) and converts it to BCD digits with
// a sequential double-dabble engine so the renderer needs no divider.
module score_counter #(
    parameter int unsigned HOLD_TICKS = 8,
    parameter int unsigned SCORE_MAX  = 255,
    parameter int unsigned FRAME_VPOS = 480
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_vpos,
    input  logic [9:0] i_hpos,
    input  logic       i_move,
    input  logic       i_collision,
    input  logic       i_restart,
    output logic [7:0] o_score,
    output logic [3:0] o_hundreds,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_bcd_valid,
    output logic       o_game_over
);

    localparam int unsigned SCORE_W = 8;
    localparam int unsigned BCD_W   = 12;
    localparam int unsigned HOLD_W  = $clog2(HOLD_TICKS);
    localparam int unsigned CNT_W   = 3;

    typedef enum logic {ST_PLAY, ST_GAME_OVER} game_state_e;
    typedef enum logic [1:0] {CV_IDLE, CV_LOAD, CV_SHIFT, CV_DONE} conv_state_e;

    game_state_e         state_q, state_d;
    conv_state_e         cv_state_q, cv_state_d;
    logic                sync1_q, move_s_q;
    logic                prev_move_q, prev_move_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                game_over_q, game_over_d;
    logic [SCORE_W-1:0]  src_q, src_d;
    logic [SCORE_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]          hundreds_q, hundreds_d;
    logic [3:0]          tens_q, tens_d;
    logic [3:0]          ones_q, ones_d;
    logic                valid_q, valid_d;

    logic                frame_tick_c;
    logic [SCORE_W-1:0]  score_inc_c;
    logic [BCD_W+SCORE_W-1:0] step_c;

    // One double-dabble iteration: add 3 to every nibble >= 5, then shift left.
    function automatic logic [BCD_W+SCORE_W-1:0] dabble_step(
        input logic [BCD_W-1:0]   bcd,
        input logic [SCORE_W-1:0] bin
    );
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        return {adj, bin} << 1;
    endfunction

    assign frame_tick_c = (i_vpos == 10'(FRAME_VPOS)) && (i_hpos == 10'd0);
    assign score_inc_c  = (score_q < SCORE_W'(SCORE_MAX)) ? score_q + 8'd1 : score_q;
    assign step_c       = dabble_step(bcd_q, bin_q);

    // Two-flop synchronizer for the asynchronous move button.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q  <= 1'b0;
            move_s_q <= 1'b0;
        end else begin
            sync1_q  <= i_move;
            move_s_q <= sync1_q;
        end
    end

    // Game state register: score, hold counter, previous-tick move level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_PLAY;
            score_q     <= '0;
            hold_q      <= '0;
            prev_move_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            hold_q      <= hold_d;
            prev_move_q <= prev_move_d;
            game_over_q <= game_over_d;
        end
    end

    // Game next-state: restart beats collision, collision beats a tick increment.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        hold_d      = hold_q;
        prev_move_d = prev_move_q;
        if (i_restart) begin
            state_d     = ST_PLAY;
            score_d     = '0;
            hold_d      = '0;
            prev_move_d = 1'b0;
        end else if (state_q == ST_PLAY) begin
            if (i_collision) begin
                state_d = ST_GAME_OVER;
            end else if (frame_tick_c) begin
                prev_move_d = move_s_q;
                if (!move_s_q) begin
                    hold_d = '0;
                end else if (!prev_move_q) begin
                    score_d = score_inc_c;
                    hold_d  = '0;
                end else if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
                    score_d = score_inc_c;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
        end
        game_over_d = (state_d == ST_GAME_OVER);
    end

    // Converter register: engine state, shift registers and published digits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cv_state_q <= CV_IDLE;
            src_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            hundreds_q <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            valid_q    <= 1'b1;
        end else begin
            cv_state_q <= cv_state_d;
            src_q      <= src_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            hundreds_q <= hundreds_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            valid_q    <= valid_d;
        end
    end

    // Converter next-state; src_q is the score being converted, so a mismatch
    // at DONE means the score moved while busy and a reload is required.
    always_comb begin
        cv_state_d = cv_state_q;
        src_d      = src_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        hundreds_d = hundreds_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        valid_d    = valid_q;
        case (cv_state_q)
            CV_IDLE: begin
                if (score_q != src_q) begin
                    cv_state_d = CV_LOAD;
                    src_d      = score_q;
                    bin_d      = score_q;
                    bcd_d      = '0;
                    bit_cnt_d  = '0;
                    valid_d    = 1'b0;
                end
            end
            CV_LOAD: begin
                {bcd_d, bin_d} = step_c;
                bit_cnt_d      = CNT_W'(1);
                cv_state_d     = CV_SHIFT;
            end
            CV_SHIFT: begin
                {bcd_d, bin_d} = step_c;
                bit_cnt_d      = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(7)) begin
                    cv_state_d = CV_DONE;
                end
            end
            CV_DONE: begin
                hundreds_d = bcd_q[11:8];
                tens_d     = bcd_q[7:4];
                ones_d     = bcd_q[3:0];
                if (score_q != src_q) begin
                    cv_state_d = CV_LOAD;
                    src_d      = score_q;
                    bin_d      = score_q;
                    bcd_d      = '0;
                    bit_cnt_d  = '0;
                end else begin
                    valid_d    = 1'b1;
                    cv_state_d = CV_IDLE;
                end
            end
            default: cv_state_d = CV_IDLE;
        endcase
    end

    assign o_score     = score_q;
    assign o_hundreds  = hundreds_q;
    assign o_tens      = tens_q;
    assign o_ones      = ones_q;
    assign o_bcd_valid = valid_q;
    assign o_game_over = game_over_q;

endmodule
